// File: rtl/i2s_fade_pkg.sv
// Shared types for the I2S soft-mute fader: state encodings and gain width helper.
// Pure declarations; no latency or flow control.
package i2s_fade_pkg;

    typedef enum logic [2:0] {
        WARMUP   = 3'd0,
        MUTED    = 3'd1,
        FADE_IN  = 3'd2,
        PASS     = 3'd3,
        FADE_OUT = 3'd4,
        ZC_WAIT  = 3'd5
    } fade_state_t;

    // Gain spans 0..2**fade_len_log2 inclusive, so one extra bit above the fraction.
    function automatic int gain_width(input int fade_len_log2);
        return fade_len_log2 + 1;
    endfunction

endpackage

// File: rtl/i2s_tx_fader_if.sv
// Sample stream between DSP and fader plus fader status; master = DSP side, slave = fader.
// Strobe-qualified samples, no backpressure.
interface i2s_tx_fader_if #(
    parameter int PKT_WIDTH = 16
);
    logic [PKT_WIDTH-1:0] pkt_i;
    logic                 pktChanged_i;
    logic                 mute_i;
    logic [PKT_WIDTH-1:0] pkt_o;
    logic                 pktChanged_o;
    logic                 muted_o;
    logic [2:0]           fadeState_o;

    modport master (
        output pkt_i, pktChanged_i, mute_i,
        input  pkt_o, pktChanged_o, muted_o, fadeState_o
    );

    modport slave (
        input  pkt_i, pktChanged_i, mute_i,
        output pkt_o, pktChanged_o, muted_o, fadeState_o
    );
endinterface

// File: rtl/i2s_tx_fader_gain_mult.sv
// Combinational signed sample x unsigned gain, floor-rounded back to sample width.
// Zero latency; no flow control.
module fade_gain_mult #(
    parameter int PKT_WIDTH     = 16,
    parameter int FADE_LEN_LOG2 = 10
) (
    input  logic [PKT_WIDTH-1:0]     pkt,
    input  logic [FADE_LEN_LOG2:0]   gain,
    output logic [PKT_WIDTH-1:0]     prod
);
    localparam int PW = PKT_WIDTH + FADE_LEN_LOG2 + 2;

    logic signed [PW-1:0] pkt_ext;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] full;

    assign pkt_ext  = {{(PW-PKT_WIDTH){pkt[PKT_WIDTH-1]}}, pkt};
    assign gain_ext = {{(PW-FADE_LEN_LOG2-1){1'b0}}, gain};
    assign full     = pkt_ext * gain_ext;

    // Arithmetic shift floors toward -inf; unity gain reproduces the input exactly.
    assign prod = PKT_WIDTH'(full >>> FADE_LEN_LOG2);

endmodule

// File: rtl/i2s_tx_fader.sv
// Soft-mute fader: warm-up hold, linear gain ramps, optional zero-cross start (ZERO_CROSS_EN).
// Output 1 cycle after each pktChanged_i strobe; no backpressure, all updates strobe-qualified.
module i2s_tx_fader
    import i2s_fade_pkg::*;
#(
    parameter int PKT_WIDTH      = 16,
    parameter int FADE_LEN_LOG2  = 10,
    parameter int WARMUP_SAMPLES = 4410,
    parameter int ZC_TIMEOUT     = 64
) (
    input  logic              sclk_i,
    input  logic              rst_n_i,
    i2s_tx_fader_if.slave     bus
);
    localparam int GW  = gain_width(FADE_LEN_LOG2);
    localparam int WCW = $clog2(WARMUP_SAMPLES + 1);

    localparam logic [GW-1:0]  UNITY     = {1'b1, {FADE_LEN_LOG2{1'b0}}};
    localparam logic [GW-1:0]  GAIN_ONE  = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_SAMPLES - 1);

    logic [1:0] rst_sync;
    logic       rst_n;

    fade_state_t          state, state_nxt, start_state;
    logic [GW-1:0]        gain, gain_nxt;
    logic [WCW-1:0]       warm_cnt, warm_cnt_nxt;
    logic [PKT_WIDTH-1:0] mult_out;
    logic [PKT_WIDTH-1:0] pkt_q;
    logic                 chg_q;
    logic                 strobe;
    logic                 mute;

    assign strobe = bus.pktChanged_i;
    assign mute   = bus.mute_i;

    // Assertion is immediate; release is retimed so no flop sees a runt reset edge.
    always_ff @(posedge sclk_i or negedge rst_n_i) begin
        if (!rst_n_i) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

`ifdef ZERO_CROSS_EN
    localparam int ZCW = $clog2(ZC_TIMEOUT + 1);
    localparam logic [ZCW-1:0] ZC_LAST = ZCW'(ZC_TIMEOUT - 1);

    logic [ZCW-1:0] zc_cnt, zc_cnt_nxt;
    logic           prev_neg;
    logic           zc_hit;

    assign start_state = ZC_WAIT;
    assign zc_hit = (bus.pkt_i == '0) || (bus.pkt_i[PKT_WIDTH-1] != prev_neg)
                    || (zc_cnt == ZC_LAST);

    always_ff @(posedge sclk_i or negedge rst_n) begin
        if (!rst_n) begin
            zc_cnt   <= '0;
            prev_neg <= 1'b0;
        end else if (strobe) begin
            zc_cnt   <= zc_cnt_nxt;
            prev_neg <= bus.pkt_i[PKT_WIDTH-1];
        end
    end
`else
    assign start_state = FADE_IN;
`endif

    always_comb begin
        state_nxt    = state;
        gain_nxt     = gain;
        warm_cnt_nxt = warm_cnt;
`ifdef ZERO_CROSS_EN
        zc_cnt_nxt   = zc_cnt;
`endif
        if (strobe) begin
            case (state)
                WARMUP: begin
                    if (warm_cnt == WARM_LAST) begin
                        warm_cnt_nxt = '0;
                        state_nxt    = mute ? MUTED : start_state;
                    end else begin
                        warm_cnt_nxt = warm_cnt + 1'b1;
                    end
                end
                MUTED: begin
                    gain_nxt = '0;
                    if (!mute) state_nxt = start_state;
                end
                FADE_IN: begin
                    // Reversal keeps the current gain so the ramp stays continuous.
                    if (mute) begin
                        state_nxt = FADE_OUT;
                    end else if (gain >= UNITY) begin
                        gain_nxt  = UNITY;
                        state_nxt = PASS;
                    end else begin
                        gain_nxt = gain + GAIN_ONE;
                        if (gain_nxt == UNITY) state_nxt = PASS;
                    end
                end
                PASS: begin
                    gain_nxt = UNITY;
                    if (mute) state_nxt = FADE_OUT;
                end
                FADE_OUT: begin
                    if (!mute) begin
                        state_nxt = FADE_IN;
                    end else if (gain == '0) begin
                        state_nxt = MUTED;
                    end else begin
                        gain_nxt = gain - GAIN_ONE;
                        if (gain_nxt == '0) state_nxt = MUTED;
                    end
                end
                ZC_WAIT: begin
`ifdef ZERO_CROSS_EN
                    gain_nxt = '0;
                    if (mute) begin
                        zc_cnt_nxt = '0;
                        state_nxt  = MUTED;
                    end else if (zc_hit) begin
                        zc_cnt_nxt = '0;
                        state_nxt  = FADE_IN;
                    end else begin
                        zc_cnt_nxt = zc_cnt + 1'b1;
                    end
`else
                    gain_nxt  = '0;
                    state_nxt = MUTED;
`endif
                end
                default: begin
                    gain_nxt  = '0;
                    state_nxt = WARMUP;
                end
            endcase
        end
    end

    always_ff @(posedge sclk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WARMUP;
            gain     <= '0;
            warm_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gain     <= gain_nxt;
            warm_cnt <= warm_cnt_nxt;
        end
    end

    // Datapath uses the gain held before this strobe's update.
    fade_gain_mult #(
        .PKT_WIDTH     (PKT_WIDTH),
        .FADE_LEN_LOG2 (FADE_LEN_LOG2)
    ) u_mult (
        .pkt  (bus.pkt_i),
        .gain (gain),
        .prod (mult_out)
    );

    always_ff @(posedge sclk_i or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q <= '0;
            chg_q <= 1'b0;
        end else begin
            chg_q <= strobe;
            if (strobe) pkt_q <= mult_out;
        end
    end

    assign bus.pkt_o        = pkt_q;
    assign bus.pktChanged_o = chg_q;
    assign bus.muted_o      = (gain == '0);
    assign bus.fadeState_o  = state;

endmodule

// File: tb/tb_i2s_tx_fader.sv
// Directed bench for i2s_tx_fader with FADE_LEN_LOG2=2 (unity=4), WARMUP_SAMPLES=3, ZC_TIMEOUT=4.
// Expected values are hand-derived from the fader state rules.
module tb_i2s_tx_fader;
    localparam int PW = 16;

    logic sclk  = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    always #5 sclk = ~sclk;

    i2s_tx_fader_if #(.PKT_WIDTH(PW)) bus ();

    i2s_tx_fader #(
        .PKT_WIDTH      (PW),
        .FADE_LEN_LOG2  (2),
        .WARMUP_SAMPLES (3),
        .ZC_TIMEOUT     (4)
    ) dut (
        .sclk_i  (sclk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    // Called at a negedge; drives one strobe and samples the registered result one negedge later.
    task automatic strobe(input logic [15:0] p, input logic m,
                          output logic [15:0] o_pkt, output logic o_chg,
                          output logic [2:0] o_state, output logic o_muted);
        bus.pkt_i        = p;
        bus.mute_i       = m;
        bus.pktChanged_i = 1'b1;
        @(negedge sclk);
        bus.pktChanged_i = 1'b0;
        o_pkt   = bus.pkt_o;
        o_chg   = bus.pktChanged_o;
        o_state = bus.fadeState_o;
        o_muted = bus.muted_o;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge sclk);
        vectors++;
        if (bus.pkt_o !== 16'h0000 || bus.pktChanged_o !== 1'b0 ||
            bus.muted_o !== 1'b1 || bus.fadeState_o !== 3'd0) begin
            errors++;
            $display("FAIL reset: pkt_o=%h chg=%b muted=%b state=%0d, expected 0000 0 1 0",
                     bus.pkt_o, bus.pktChanged_o, bus.muted_o, bus.fadeState_o);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge sclk);
        vectors++;
        if (bus.fadeState_o !== 3'd0 || bus.muted_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: state=%0d muted=%b, expected 0 1",
                     bus.fadeState_o, bus.muted_o);
        end
    endtask

    task automatic test_startup();
        logic [15:0] ep [9] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1000,
                               16'h2000, 16'h3000, 16'h4000, 16'h4000};
        logic [2:0]  es [9] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3};
        logic        em [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [15:0] o; logic c; logic [2:0] s; logic mu;
        for (int i = 0; i < 9; i++) begin
            strobe(16'h4000, 1'b0, o, c, s, mu);
            vectors++;
            if (o !== ep[i] || c !== 1'b1 || s !== es[i] || mu !== em[i]) begin
                errors++;
                $display("FAIL startup[%0d]: pkt_o=%h chg=%b state=%0d muted=%b, expected %h 1 %0d %b",
                         i, o, c, s, mu, ep[i], es[i], em[i]);
            end
        end
        @(negedge sclk);
        vectors++;
        if (bus.pktChanged_o !== 1'b0 || bus.pkt_o !== 16'h4000 || bus.fadeState_o !== 3'd3) begin
            errors++;
            $display("FAIL hold: chg=%b pkt_o=%h state=%0d, expected 0 4000 3",
                     bus.pktChanged_o, bus.pkt_o, bus.fadeState_o);
        end
    endtask

    task automatic test_rounding();
        logic [15:0] ip [7] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
        logic        im [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [15:0] ep [7] = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
        logic [2:0]  es [7] = '{3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd1, 3'd1};
        logic        em [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] o; logic c; logic [2:0] s; logic mu;
        for (int i = 0; i < 7; i++) begin
            strobe(ip[i], im[i], o, c, s, mu);
            vectors++;
            if (o !== ep[i] || c !== 1'b1 || s !== es[i] || mu !== em[i]) begin
                errors++;
                $display("FAIL rounding[%0d]: pkt_o=%h chg=%b state=%0d muted=%b, expected %h 1 %0d %b",
                         i, o, c, s, mu, ep[i], es[i], em[i]);
            end
        end
    endtask

    task automatic test_fault();
        logic        im [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [15:0] ep [8] = '{16'h0000, 16'h0000, 16'h1000, 16'h2000,
                               16'h2000, 16'h1000, 16'h0000, 16'h0000};
        logic [2:0]  es [8] = '{3'd2, 3'd2, 3'd2, 3'd4, 3'd4, 3'd1, 3'd1, 3'd1};
        logic        em [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] o; logic c; logic [2:0] s; logic mu;
        for (int i = 0; i < 8; i++) begin
            strobe(16'h4000, im[i], o, c, s, mu);
            vectors++;
            if (o !== ep[i] || c !== 1'b1 || s !== es[i] || mu !== em[i]) begin
                errors++;
                $display("FAIL fault[%0d]: pkt_o=%h chg=%b state=%0d muted=%b, expected %h 1 %0d %b",
                         i, o, c, s, mu, ep[i], es[i], em[i]);
            end
        end
    endtask

    task automatic test_reversal();
        logic        im [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [15:0] ep [10] = '{16'h0000, 16'h0000, 16'h1000, 16'h2000, 16'h3000,
                                16'h4000, 16'h4000, 16'h3000, 16'h3000, 16'h4000};
        logic [2:0]  es [10] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd2, 3'd3, 3'd3};
        logic [15:0] o; logic c; logic [2:0] s; logic mu;
        for (int i = 0; i < 10; i++) begin
            strobe(16'h4000, im[i], o, c, s, mu);
            vectors++;
            if (o !== ep[i] || c !== 1'b1 || s !== es[i]) begin
                errors++;
                $display("FAIL reversal[%0d]: pkt_o=%h chg=%b state=%0d, expected %h 1 %0d",
                         i, o, c, s, ep[i], es[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] ep [5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1000};
        logic [2:0]  es [5] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd2};
        logic [15:0] o; logic c; logic [2:0] s; logic mu;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.pkt_o !== 16'h0000 || bus.muted_o !== 1'b1 || bus.fadeState_o !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: pkt_o=%h muted=%b state=%0d, expected 0000 1 0",
                     bus.pkt_o, bus.muted_o, bus.fadeState_o);
        end
        @(negedge sclk);
        rst_n = 1'b1;
        repeat (3) @(negedge sclk);
        for (int i = 0; i < 5; i++) begin
            strobe(16'h4000, 1'b0, o, c, s, mu);
            vectors++;
            if (o !== ep[i] || c !== 1'b1 || s !== es[i]) begin
                errors++;
                $display("FAIL post_reset[%0d]: pkt_o=%h chg=%b state=%0d, expected %h 1 %0d",
                         i, o, c, s, ep[i], es[i]);
            end
        end
    endtask

    task automatic test_zero_cross();
        logic [15:0] ip [17] = '{16'd100, 16'd100, 16'd100, 16'd100, 16'd90, 16'hFFFB,
                                16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100,
                                16'd100, 16'd100, 16'd100, 16'd100};
        logic        im [17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  es [17] = '{3'd0, 3'd0, 3'd5, 3'd5, 3'd5, 3'd2,
                                3'd4, 3'd1, 3'd5, 3'd5, 3'd5, 3'd5, 3'd2,
                                3'd4, 3'd1, 3'd5, 3'd1};
        logic [15:0] o; logic c; logic [2:0] s; logic mu;
        for (int i = 0; i < 17; i++) begin
            strobe(ip[i], im[i], o, c, s, mu);
            vectors++;
            if (o !== 16'h0000 || c !== 1'b1 || s !== es[i]) begin
                errors++;
                $display("FAIL zero_cross[%0d]: pkt_o=%h chg=%b state=%0d, expected 0000 1 %0d",
                         i, o, c, s, es[i]);
            end
        end
    endtask

    initial begin
        bus.pkt_i        = '0;
        bus.pktChanged_i = 1'b0;
        bus.mute_i       = 1'b0;
        test_reset();
`ifdef ZERO_CROSS_EN
        test_zero_cross();
`else
        test_startup();
        test_rounding();
        test_fault();
        test_reversal();
        test_async_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
